// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
// Imported by the fetch interface, the next-PC selector and the fetch top.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        VALID = 2'd1,
        ERR   = 2'd2
    } fetch_state_e;

    // Branch targets and fall-through addresses must stay on a word boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Bundle of the instruction-memory handshake and the decode-side signals.
// The master side is the fetch stage; the slave side is memory plus decode.
interface pc_fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            stall;
    logic            pc_src;
    logic [XLEN-1:0] imm_data;
    logic            fetch_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_valid,
        output pc,
        output pc_plus4,
        input  stall,
        input  pc_src,
        input  imm_data,
        output fetch_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        input  pc,
        input  pc_plus4,
        output stall,
        output pc_src,
        output imm_data,
        input  fetch_err
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC choice: fall-through (pc+4) or PC-relative branch target.
// Both sums wrap modulo 2^32; misalignment of the chosen target is flagged.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_data,
    input  logic            pc_src,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] branch_pc;

    always_comb begin
        seq_pc     = pc + 32'd4;
        branch_pc  = pc + imm_data;
        next_pc    = pc_src ? branch_pc : seq_pc;
        misaligned = is_misaligned(next_pc);
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and single-outstanding instruction fetch feeding decode.
// All architectural state (state, pc, instr, error flag) is held here.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            err_q, err_d;
    logic            rel_q;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            req_active;
    logic            consume;

    pc_next_sel u_next_sel (
        .pc         (pc_q),
        .imm_data   (bus.imm_data),
        .pc_src     (bus.pc_src),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    // Request is gated by a registered reset release so it cannot rise
    // in the same cycle rst_n deasserts, and drops the instant rst_n asserts.
    always_comb begin
        req_active = rel_q && (state_q == REQ);
        consume    = (state_q == VALID) && !bus.stall;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;

        unique case (state_q)
            REQ: begin
                if (req_active && bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (consume) begin
                    if (next_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            rel_q   <= 1'b1;
        end
    end

    always_comb begin
        bus.imem_req    = req_active;
        bus.imem_addr   = pc_q;
        bus.instr       = instr_q;
        bus.instr_valid = (state_q == VALID);
        bus.pc          = pc_q;
        bus.pc_plus4    = pc_q + 32'd4;
        bus.fetch_err   = err_q;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage sitting directly upstream of the immediate generator and decoder. It holds the architectural PC and issues one request/acknowledge fetch at a time to instruction memory. It presents the fetched instruction, with its PC, to the decode stage. On each consumed instruction it selects the next PC, either PC+4 or the PC-relative branch target PC+imm_data, using the sign-extended B-type immediate coming back from the immediate generator.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory completion; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered instruction to decode/immediate generation.
- instr_valid  out  1  instr and pc are valid.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc+4, combinational, for the JAL/link path.
- stall  in  1  downstream cannot consume instr this cycle.
- pc_src  in  1  1 = branch taken for the current instr; sampled only at consume.
- imm_data  in  32  sign-extended branch offset for the current instr.
- fetch_err  out  1  sticky misaligned-target error.

## Operation
- States: REQ, VALID, ERR.
- REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ack: capture imem_rdata into instr and go to VALID.
- VALID:
  - imem_req=0, instr_valid=1.
  - Consume occurs when instr_valid=1 and stall=0. While stall=1, instr and pc are held and the state stays VALID.
  - At consume, next = pc_src ? pc+imm_data : pc+4. Both additions are 32-bit modulo 2^32, so wrap-around past 32'hFFFF_FFFC is legal and silent.
  - At consume, if next[1:0]≠0: pc is unchanged, fetch_err=1, go to ERR.
  - Otherwise pc←next and go to REQ.
- ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Held until reset; no further fetches.
- pc_src and imm_data are don't-care outside a consume cycle.
- imem_ack while imem_req=0 is ignored.

## Timing
- Reset (asynchronous assert) forces:
  - state=REQ, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, fetch_err=0.
  - imem_req=0 while rst_n=0.
- imem_req goes to 1 in the first cycle after rst_n deasserts; it is driven from the state register, gated by a one-flop registered reset release.
- Fetch latency: ack in cycle N gives instr_valid=1 in cycle N+1.
- Back-to-back throughput: a consume in cycle M gives imem_req=1 with the new address in cycle M+1. Minimum period is 2 cycles per instruction when ack is zero-wait.
- imem_addr is stable and imem_req stays high from request to ack. The request is never withdrawn except by reset.
- Reset during an outstanding request abandons the request; the ack for it is ignored.
- stall has no effect in the REQ and ERR states.
- pc_plus4 is combinational from the pc register, with zero latency.

## Structure
- Shared package fetch_pkg holds:
  - state enum {REQ, VALID, ERR};
  - NOP_INSTR = 32'h0000_0013;
  - XLEN = 32.
- One combinational sub-module, pc_next_sel:
  - inputs pc, imm_data, pc_src;
  - outputs next_pc and misaligned.
- All flops live in pc_fetch.

## Test plan
- Reset release with RESET_PC=0 and zero-wait ack: imem_addr sequence 0, 4, 8 with stall=0, pc_src=0; instr_valid pulses every 2nd cycle.
- Taken branch: at pc=32'h10, pc_src=1, imm_data=32'hFFFF_FFF8 gives next imem_addr=32'h08. With imm_data=32'h0000_0100 it gives 32'h110.
- Stall: hold stall=1 for 5 cycles in VALID. instr, pc and instr_valid stay constant, imem_req=0 throughout, and fetch resumes the cycle after stall drops.
- Memory wait states: ack delayed 3 cycles. imem_req and imem_addr stay stable throughout, and instr equals the rdata sampled on the ack cycle.
- Misaligned target: pc=32'h20, pc_src=1, imm_data=32'h0000_0006. fetch_err=1 next cycle, instr_valid=0, no further imem_req, and the state is cleared only by rst_n.
- Wrap and mid-request reset:
  - pc=32'hFFFF_FFFC, pc_src=0 gives next imem_addr=0.
  - Asserting rst_n=0 while imem_req=1 immediately zeroes imem_req; after release the fetch restarts at RESET_PC.
